// File: rtl/aquila_mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-side signals of the Aquila line-fill arbiter.
// Signal suffixes are relative to the arbiter: _i enters the arbiter, _o leaves it.
// The slave modport is the arbiter's view; the master modport is the view of the
// surrounding caches and memory model that drive and observe it.
interface aquila_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
);
   logic                  icache_strobe_i;
   logic [ADDR_WIDTH-1:0] icache_addr_i;
   logic                  icache_done_o;
   logic [LINE_WIDTH-1:0] icache_data_o;

   logic                  dcache_strobe_i;
   logic [ADDR_WIDTH-1:0] dcache_addr_i;
   logic                  dcache_rw_i;
   logic [LINE_WIDTH-1:0] dcache_data_i;
   logic                  dcache_done_o;
   logic [LINE_WIDTH-1:0] dcache_data_o;

   logic                  mem_strobe_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic                  mem_rw_o;
   logic [LINE_WIDTH-1:0] mem_data_o;
   logic                  mem_done_i;
   logic [LINE_WIDTH-1:0] mem_data_i;

   logic                  timeout_o;

   modport slave (
      input  icache_strobe_i, icache_addr_i,
      output icache_done_o, icache_data_o,
      input  dcache_strobe_i, dcache_addr_i, dcache_rw_i, dcache_data_i,
      output dcache_done_o, dcache_data_o,
      output mem_strobe_o, mem_addr_o, mem_rw_o, mem_data_o,
      input  mem_done_i, mem_data_i,
      output timeout_o
   );

   modport master (
      output icache_strobe_i, icache_addr_i,
      input  icache_done_o, icache_data_o,
      output dcache_strobe_i, dcache_addr_i, dcache_rw_i, dcache_data_i,
      input  dcache_done_o, dcache_data_o,
      input  mem_strobe_o, mem_addr_o, mem_rw_o, mem_data_o,
      output mem_done_i, mem_data_i,
      input  timeout_o
   );
endinterface

// File: rtl/aquila_mem_arbiter.sv
// Two-master line-fill arbiter: the I-cache (read-only) and D-cache (read/write)
// share one 256-bit memory port. Each master may hold one outstanding request,
// one memory transaction is in flight at a time, ties alternate round-robin,
// and an optional watchdog forces completion when memory never answers.
module aquila_mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256,
   parameter int TIMEOUT    = 0
) (
   input logic                  clk_i,
   input logic                  rst_i,
   aquila_mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   state_t                state_q, state_d;

   logic                  iPend_q, iPend_d;
   logic [ADDR_WIDTH-1:0] iAddr_q, iAddr_d;
   logic                  dPend_q, dPend_d;
   logic [ADDR_WIDTH-1:0] dAddr_q, dAddr_d;
   logic                  dRw_q, dRw_d;
   logic [LINE_WIDTH-1:0] dWdata_q, dWdata_d;

   // lastGrant_q doubles as the owner of the transaction in flight (0 = I, 1 = D)
   logic                  lastGrant_q, lastGrant_d;

   logic                  memStrobe_q, memStrobe_d;
   logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
   logic                  memRw_q, memRw_d;
   logic [LINE_WIDTH-1:0] memData_q, memData_d;

   logic [LINE_WIDTH-1:0] iData_q, iData_d;
   logic [LINE_WIDTH-1:0] dData_q, dData_d;

   logic                  timeout_q, timeout_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic                  iRelease;
   logic                  dRelease;
   logic                  iCand;
   logic                  dCand;
   logic                  grantD;
   logic [ADDR_WIDTH-1:0] iReqAddr;
   logic [ADDR_WIDTH-1:0] dReqAddr;
   logic                  dReqRw;
   logic [LINE_WIDTH-1:0] dReqData;

   // Request view seen by the arbiter: a pending request wins, otherwise a same-cycle
   // strobe bypasses the pending register so an idle arbiter grants without delay.
   always_comb begin
      iRelease = (state_q == RESP) && !lastGrant_q;
      dRelease = (state_q == RESP) && lastGrant_q;
      iCand    = iPend_q || bus.icache_strobe_i;
      dCand    = dPend_q || bus.dcache_strobe_i;
      iReqAddr = iPend_q ? iAddr_q : bus.icache_addr_i;
      dReqAddr = dPend_q ? dAddr_q : bus.dcache_addr_i;
      dReqRw   = dPend_q ? dRw_q : bus.dcache_rw_i;
      dReqData = dPend_q ? dWdata_q : bus.dcache_data_i;
      // with both waiting, serve the master opposite the previous grant
      grantD   = dCand && (!iCand || !lastGrant_q);
   end

   // Next-state logic for the FSM, the pending slots, the memory request registers,
   // the response data registers and the watchdog.
   always_comb begin
      state_d     = state_q;
      iPend_d     = iPend_q;
      iAddr_d     = iAddr_q;
      dPend_d     = dPend_q;
      dAddr_d     = dAddr_q;
      dRw_d       = dRw_q;
      dWdata_d    = dWdata_q;
      lastGrant_d = lastGrant_q;
      memStrobe_d = 1'b0;
      memAddr_d   = memAddr_q;
      memRw_d     = memRw_q;
      memData_d   = memData_q;
      iData_d     = iData_q;
      dData_d     = dData_q;
      timeout_d   = timeout_q;
      cnt_d       = cnt_q;

      // the slot being answered frees up this cycle, so a strobe now refills it
      if (iRelease) begin
         iPend_d = 1'b0;
      end
      if (dRelease) begin
         dPend_d = 1'b0;
      end
      if (bus.icache_strobe_i && (!iPend_q || iRelease)) begin
         iPend_d = 1'b1;
         iAddr_d = bus.icache_addr_i;
      end
      if (bus.dcache_strobe_i && (!dPend_q || dRelease)) begin
         dPend_d  = 1'b1;
         dAddr_d  = bus.dcache_addr_i;
         dRw_d    = bus.dcache_rw_i;
         dWdata_d = bus.dcache_data_i;
      end

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (iCand || dCand) begin
               memStrobe_d = 1'b1;
               lastGrant_d = grantD;
               state_d     = WAIT;
               if (grantD) begin
                  memAddr_d = dReqAddr;
                  memRw_d   = dReqRw;
                  memData_d = dReqData;
               end else begin
                  memAddr_d = iReqAddr;
                  memRw_d   = 1'b0;
                  memData_d = '0;
               end
            end
         end
         WAIT: begin
            // the strobe cycle is the entry cycle and restarts the watchdog
            if (memStrobe_q) begin
               cnt_d = '0;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (bus.mem_done_i) begin
               state_d = RESP;
               if (!lastGrant_q) begin
                  iData_d = bus.mem_data_i;
               end else if (!memRw_q) begin
                  dData_d = bus.mem_data_i;
               end
            end else if ((TIMEOUT != 0) && !memStrobe_q && (cnt_q == CNT_MAX)) begin
               timeout_d = 1'b1;
               state_d   = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset drops any in-flight work and zeroes every output.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         iPend_q     <= 1'b0;
         iAddr_q     <= '0;
         dPend_q     <= 1'b0;
         dAddr_q     <= '0;
         dRw_q       <= 1'b0;
         dWdata_q    <= '0;
         lastGrant_q <= 1'b1;
         memStrobe_q <= 1'b0;
         memAddr_q   <= '0;
         memRw_q     <= 1'b0;
         memData_q   <= '0;
         iData_q     <= '0;
         dData_q     <= '0;
         timeout_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         iPend_q     <= iPend_d;
         iAddr_q     <= iAddr_d;
         dPend_q     <= dPend_d;
         dAddr_q     <= dAddr_d;
         dRw_q       <= dRw_d;
         dWdata_q    <= dWdata_d;
         lastGrant_q <= lastGrant_d;
         memStrobe_q <= memStrobe_d;
         memAddr_q   <= memAddr_d;
         memRw_q     <= memRw_d;
         memData_q   <= memData_d;
         iData_q     <= iData_d;
         dData_q     <= dData_d;
         timeout_q   <= timeout_d;
         cnt_q       <= cnt_d;
      end
   end

   // Completion pulses come straight from the RESP state and its owner, so the two
   // dones can never coincide.
   always_comb begin
      bus.icache_done_o = (state_q == RESP) && !lastGrant_q;
      bus.dcache_done_o = (state_q == RESP) && lastGrant_q;
      bus.icache_data_o = iData_q;
      bus.dcache_data_o = dData_q;
      bus.mem_strobe_o  = memStrobe_q;
      bus.mem_addr_o    = memAddr_q;
      bus.mem_rw_o      = memRw_q;
      bus.mem_data_o    = memData_q;
      bus.timeout_o     = timeout_q;
   end

endmodule

// File: tb/tb_aquila_mem_arbiter.sv
// Directed bench for aquila_mem_arbiter (TIMEOUT = 8). Expected memory transactions
// and expected response lines are queued when stimulus is driven and checked by a
// monitor when the DUT produces them; exact-cycle checks sit in the main sequence.
module tb_aquila_mem_arbiter;

   localparam int AW = 32;
   localparam int LW = 256;

   localparam logic [LW-1:0] DATA_A5  = {32{8'hA5}};
   localparam logic [LW-1:0] DATA_WR  = {8{32'h12345678}};
   localparam logic [LW-1:0] DATA_JNK = {8{32'hDEADBEEF}};
   localparam logic [LW-1:0] DATA_3C  = {32{8'h3C}};
   localparam logic [LW-1:0] X1 = {8{32'h11110001}};
   localparam logic [LW-1:0] X2 = {8{32'h22220002}};
   localparam logic [LW-1:0] X3 = {8{32'h33330003}};
   localparam logic [LW-1:0] X4 = {8{32'h44440004}};
   localparam logic [LW-1:0] X5 = {8{32'h55550005}};
   localparam logic [LW-1:0] X6 = {8{32'h66660006}};
   localparam logic [LW-1:0] X7 = {8{32'h77770007}};
   localparam logic [LW-1:0] X8 = {8{32'h88880008}};
   localparam logic [LW-1:0] X9 = {8{32'h99990009}};
   localparam logic [LW-1:0] WR2 = {8{32'hCAFE0102}};

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          rw;
      logic [LW-1:0] data;
   } memTxn_t;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   failures;
   int   memStrobeCount;
   int   iDoneCount;

   memTxn_t       memExp[$];
   logic [LW-1:0] iExp[$];
   logic [LW-1:0] dExp[$];
   memTxn_t       monTxn;
   logic [LW-1:0] monData;

   aquila_mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

   aquila_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT(8)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it, and reports tag/observed/expected on a miss.
   task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge and drop the one-cycle pulses.
   task automatic nextCycle();
      @(posedge clk);
      #1;
      cyc++;
      bus.icache_strobe_i = 1'b0;
      bus.dcache_strobe_i = 1'b0;
      bus.mem_done_i      = 1'b0;
   endtask

   task automatic goTo(input int c);
      while (cyc < c) nextCycle();
   endtask

   // Drive one request pulse for the current cycle and queue what it should produce.
   task automatic applyStimulus(input bit isD, input logic [AW-1:0] addr, input logic rw,
                                input logic [LW-1:0] wdata, input bit expectTxn);
      memTxn_t t;
      if (isD) begin
         bus.dcache_strobe_i = 1'b1;
         bus.dcache_addr_i   = addr;
         bus.dcache_rw_i     = rw;
         bus.dcache_data_i   = wdata;
      end else begin
         bus.icache_strobe_i = 1'b1;
         bus.icache_addr_i   = addr;
      end
      if (expectTxn) begin
         t.addr = addr;
         t.rw   = isD ? rw : 1'b0;
         t.data = (isD && rw) ? wdata : '0;
         memExp.push_back(t);
      end
   endtask

   task automatic memRespond(input logic [LW-1:0] data);
      bus.mem_done_i = 1'b1;
      bus.mem_data_i = data;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_mem_strobe"}, LW'(bus.mem_strobe_o), '0);
      checkOutput({tag, "_mem_addr"}, LW'(bus.mem_addr_o), '0);
      checkOutput({tag, "_mem_rw"}, LW'(bus.mem_rw_o), '0);
      checkOutput({tag, "_mem_data"}, bus.mem_data_o, '0);
      checkOutput({tag, "_i_done"}, LW'(bus.icache_done_o), '0);
      checkOutput({tag, "_d_done"}, LW'(bus.dcache_done_o), '0);
      checkOutput({tag, "_i_data"}, bus.icache_data_o, '0);
      checkOutput({tag, "_d_data"}, bus.dcache_data_o, '0);
      checkOutput({tag, "_timeout"}, LW'(bus.timeout_o), '0);
   endtask

   task automatic resetDut();
      rst = 1'b1;
      nextCycle();
      nextCycle();
      checkAllZero("reset");
      rst = 1'b0;
      cyc = 0;
      memExp.delete();
      iExp.delete();
      dExp.delete();
   endtask

   // Scoreboard monitor: every memory strobe and every done is matched against the queues.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.icache_done_o && bus.dcache_done_o) begin
            checkOutput("dual_done", LW'(bus.dcache_done_o), '0);
         end
         if (bus.mem_strobe_o) begin
            memStrobeCount++;
            if (memExp.size() == 0) begin
               checkOutput("mem_unexpected", LW'(bus.mem_strobe_o), '0);
            end else begin
               monTxn = memExp.pop_front();
               checkOutput("mem_addr", LW'(bus.mem_addr_o), LW'(monTxn.addr));
               checkOutput("mem_rw", LW'(bus.mem_rw_o), LW'(monTxn.rw));
               if (monTxn.rw) checkOutput("mem_wdata", bus.mem_data_o, monTxn.data);
            end
         end
         if (bus.icache_done_o) begin
            iDoneCount++;
            if (iExp.size() == 0) begin
               checkOutput("i_done_unexpected", LW'(bus.icache_done_o), '0);
            end else begin
               monData = iExp.pop_front();
               checkOutput("i_data", bus.icache_data_o, monData);
            end
         end
         if (bus.dcache_done_o) begin
            if (dExp.size() == 0) begin
               checkOutput("d_done_unexpected", LW'(bus.dcache_done_o), '0);
            end else begin
               monData = dExp.pop_front();
               checkOutput("d_data", bus.dcache_data_o, monData);
            end
         end
      end
   end

   // Absolute time bound so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "[TB] simulation time bound exceeded");
   end

   initial begin
      checks = 0;
      failures = 0;
      cyc = 0;
      memStrobeCount = 0;
      iDoneCount = 0;
      rst = 1'b1;
      bus.icache_strobe_i = 1'b0;
      bus.icache_addr_i   = '0;
      bus.dcache_strobe_i = 1'b0;
      bus.dcache_addr_i   = '0;
      bus.dcache_rw_i     = 1'b0;
      bus.dcache_data_i   = '0;
      bus.mem_done_i      = 1'b0;
      bus.mem_data_i      = '0;

      // I-cache read only
      resetDut();
      goTo(10); applyStimulus(1'b0, 32'h0000_1000, 1'b0, '0, 1'b1); iExp.push_back(DATA_A5);
      goTo(11);
      checkOutput("t1_strobe_n1", LW'(bus.mem_strobe_o), LW'(1'b1));
      checkOutput("t1_addr_n1", LW'(bus.mem_addr_o), LW'(32'h1000));
      goTo(12);
      checkOutput("t1_strobe_once", LW'(bus.mem_strobe_o), '0);
      checkOutput("t1_addr_held", LW'(bus.mem_addr_o), LW'(32'h1000));
      goTo(14); memRespond(DATA_A5);
      goTo(15);
      checkOutput("t1_i_done", LW'(bus.icache_done_o), LW'(1'b1));
      checkOutput("t1_d_done", LW'(bus.dcache_done_o), '0);
      goTo(16);
      checkOutput("t1_i_done_pulse", LW'(bus.icache_done_o), '0);
      checkOutput("t1_i_data_held", bus.icache_data_o, DATA_A5);

      // D-cache write
      resetDut();
      goTo(5); applyStimulus(1'b1, 32'h0000_2000, 1'b1, DATA_WR, 1'b1); dExp.push_back('0);
      goTo(6);
      checkOutput("t2_strobe", LW'(bus.mem_strobe_o), LW'(1'b1));
      checkOutput("t2_rw", LW'(bus.mem_rw_o), LW'(1'b1));
      checkOutput("t2_wdata", bus.mem_data_o, DATA_WR);
      goTo(8); memRespond(DATA_JNK);
      goTo(9);
      checkOutput("t2_d_done", LW'(bus.dcache_done_o), LW'(1'b1));
      checkOutput("t2_d_data_unchanged", bus.dcache_data_o, '0);

      // Contention and round-robin
      resetDut();
      goTo(3);
      applyStimulus(1'b0, 32'h0000_4000, 1'b0, '0, 1'b1); iExp.push_back(X1);
      applyStimulus(1'b1, 32'h0000_5000, 1'b0, '0, 1'b1); dExp.push_back(X2);
      goTo(4);
      checkOutput("t3_first_i_addr", LW'(bus.mem_addr_o), LW'(32'h4000));
      memRespond(X1);
      goTo(5);
      checkOutput("t3_done_strobe_cycle", LW'(bus.icache_done_o), LW'(1'b1));
      applyStimulus(1'b0, 32'h0000_6000, 1'b0, '0, 1'b0);
      goTo(6);
      checkOutput("t3_idle_no_strobe", LW'(bus.mem_strobe_o), '0);
      goTo(7);
      checkOutput("t3_d_resp_plus2", LW'(bus.mem_strobe_o), LW'(1'b1));
      checkOutput("t3_d_addr", LW'(bus.mem_addr_o), LW'(32'h5000));
      memExp.push_back('{addr: 32'h0000_6000, rw: 1'b0, data: '0}); iExp.push_back(X3);
      goTo(8); memRespond(X2);
      goTo(11);
      checkOutput("t3_resp_capture_addr", LW'(bus.mem_addr_o), LW'(32'h6000));
      goTo(12); memRespond(X3);
      goTo(14);
      applyStimulus(1'b1, 32'h0000_7000, 1'b1, WR2, 1'b1); dExp.push_back(X2);
      applyStimulus(1'b0, 32'h0000_8000, 1'b0, '0, 1'b1); iExp.push_back(X4);
      goTo(15);
      checkOutput("t3_pair2_d_first", LW'(bus.mem_addr_o), LW'(32'h7000));
      goTo(16); memRespond(DATA_JNK);
      goTo(19);
      checkOutput("t3_pair2_i_second", LW'(bus.mem_addr_o), LW'(32'h8000));
      memRespond(X4);
      goTo(20);
      checkOutput("t3_final_i_done", LW'(bus.icache_done_o), LW'(1'b1));

      // Repeated strobe while pending is ignored
      resetDut();
      memStrobeCount = 0;
      iDoneCount = 0;
      goTo(10); applyStimulus(1'b0, 32'h0000_1000, 1'b0, '0, 1'b1); iExp.push_back(DATA_3C);
      goTo(11); applyStimulus(1'b0, 32'h0000_3000, 1'b0, '0, 1'b0);
      goTo(12);
      checkOutput("t4_addr_kept", LW'(bus.mem_addr_o), LW'(32'h1000));
      goTo(13); memRespond(DATA_3C);
      goTo(16);
      checkOutput("t4_no_second_strobe", LW'(bus.mem_strobe_o), '0);
      goTo(20);
      checkOutput("t4_strobe_count", LW'(memStrobeCount), LW'(1));
      checkOutput("t4_done_count", LW'(iDoneCount), LW'(1));

      // Watchdog with TIMEOUT = 8
      resetDut();
      goTo(2); applyStimulus(1'b0, 32'h0000_A000, 1'b0, '0, 1'b1); iExp.push_back(X5);
      goTo(4); memRespond(X5);
      goTo(8); applyStimulus(1'b0, 32'h0000_B000, 1'b0, '0, 1'b1); iExp.push_back(X5);
      goTo(18);
      checkOutput("t5_timeout_early", LW'(bus.timeout_o), '0);
      checkOutput("t5_done_early", LW'(bus.icache_done_o), '0);
      goTo(19);
      checkOutput("t5_timeout_set", LW'(bus.timeout_o), LW'(1'b1));
      checkOutput("t5_forced_done", LW'(bus.icache_done_o), LW'(1'b1));
      checkOutput("t5_data_unchanged", bus.icache_data_o, X5);
      goTo(20);
      checkOutput("t5_timeout_sticky", LW'(bus.timeout_o), LW'(1'b1));
      memRespond(DATA_JNK);
      goTo(21);
      checkOutput("t5_stray_done_ignored", LW'(bus.icache_done_o), '0);
      goTo(22); applyStimulus(1'b1, 32'h0000_C000, 1'b0, '0, 1'b1); dExp.push_back(X6);
      goTo(24); memRespond(X6);
      goTo(25);
      checkOutput("t5_next_d_done", LW'(bus.dcache_done_o), LW'(1'b1));
      checkOutput("t5_next_d_data", bus.dcache_data_o, X6);

      // Reset during WAIT, continuing from the watchdog state
      goTo(27); applyStimulus(1'b0, 32'h0000_D000, 1'b0, '0, 1'b1); iExp.push_back(X9);
      goTo(28);
      checkOutput("t6_in_wait", LW'(bus.mem_strobe_o), LW'(1'b1));
      goTo(30);
      rst = 1'b1;
      #1;
      checkAllZero("t6_midreset");
      iExp.delete();
      memExp.delete();
      goTo(32); rst = 1'b0;
      goTo(33); memRespond(DATA_JNK);
      goTo(34);
      checkOutput("t6_late_done_i", LW'(bus.icache_done_o), '0);
      checkOutput("t6_late_done_d", LW'(bus.dcache_done_o), '0);
      checkOutput("t6_no_strobe", LW'(bus.mem_strobe_o), '0);
      goTo(35);
      applyStimulus(1'b0, 32'h0000_E000, 1'b0, '0, 1'b1); iExp.push_back(X7);
      applyStimulus(1'b1, 32'h0000_F000, 1'b0, '0, 1'b1); dExp.push_back(X8);
      goTo(36);
      checkOutput("t6_i_priority", LW'(bus.mem_addr_o), LW'(32'hE000));
      goTo(37); memRespond(X7);
      goTo(40);
      checkOutput("t6_d_after", LW'(bus.mem_addr_o), LW'(32'hF000));
      memRespond(X8);
      goTo(42);

      checkOutput("mem_queue_drained", LW'(memExp.size()), '0);
      checkOutput("i_queue_drained", LW'(iExp.size()), '0);
      checkOutput("d_queue_drained", LW'(dExp.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aquila_mem_arbiter.md
# aquila_mem_arbiter

Two-master arbiter that shares the single 256-bit line-fill memory port between the Aquila I-cache (read-only) and D-cache (read/write) miss paths. It latches one outstanding request per master and issues one transaction at a time to the downstream memory (DDR controller or simulation RAM). It steers each response back to its originator and alternates grants round-robin when both masters are waiting. It sits between aquila_top's M_ICACHE_*/M_DCACHE_* ports and the memory model/controller.

## Interface
- ADDR_WIDTH, 32, byte address width
- LINE_WIDTH, 256, cache-line data width
- TIMEOUT, 0, max cycles in WAIT before forced completion; 0 disables the watchdog
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- icache_strobe_i  in  1  one-cycle request pulse from I-cache (read)
- icache_addr_i  in  ADDR_WIDTH  line address, sampled with strobe
- icache_done_o  out  1  one-cycle completion pulse
- icache_data_o  out  LINE_WIDTH  read line; valid with done, held until next I-cache completion
- dcache_strobe_i  in  1  one-cycle request pulse from D-cache
- dcache_addr_i  in  ADDR_WIDTH  line address, sampled with strobe
- dcache_rw_i  in  1  0 = read, 1 = write, sampled with strobe
- dcache_data_i  in  LINE_WIDTH  write line, sampled with strobe
- dcache_done_o  out  1  one-cycle completion pulse
- dcache_data_o  out  LINE_WIDTH  read line; updated only on D-cache read completion
- mem_strobe_o  out  1  one-cycle transaction start to memory
- mem_addr_o / mem_rw_o / mem_data_o  out  ADDR_WIDTH / 1 / LINE_WIDTH  registered request; held from strobe until next grant
- mem_done_i  in  1  one-cycle completion from memory
- mem_data_i  in  LINE_WIDTH  read data, valid with mem_done_i
- timeout_o  out  1  sticky; set when the watchdog fires, cleared only by reset

## Operation
- Per-master pending registers: i_pend/i_addr_q; d_pend/d_addr_q/d_rw_q/d_wdata_q. A strobe loads them when that master has no pending request. A strobe while pending is ignored.
- last_grant bit: 0 = I, 1 = D. Resets to 1, so the I-cache wins the first tie.
- FSM IDLE -> WAIT -> RESP -> IDLE.
- IDLE: candidates are pending requests OR same-cycle strobes (strobe bypasses the pending register). If only one master is a candidate, grant it. If both, grant the master opposite last_grant. On grant: register mem_addr/rw/data, set mem_strobe_o for exactly the next cycle, update last_grant, go to WAIT.
- WAIT: mem_done_i is accepted in any WAIT cycle, including the mem_strobe_o cycle. On mem_done_i, capture mem_data_i into the granted master's data register (I-cache always; D-cache only if rw = 0) and go to RESP. The watchdog counter resets on entry. If TIMEOUT != 0 and the counter reaches TIMEOUT, set timeout_o, go to RESP, and leave the data registers unchanged.
- RESP: pulse the granted master's done_o for one cycle, clear its pending bit, go to IDLE. A strobe from the same master in the RESP cycle is captured as a new request.
- mem_done_i outside WAIT is ignored.
- Reset (any time, including mid-transaction): state IDLE, pending cleared, last_grant = 1, counter 0. All outputs 0: strobes, dones, timeout_o, mem_addr/rw/data, both data outputs. In-flight requests are dropped; masters re-issue.

## Timing
- Strobe in cycle N with arbiter idle and no contention -> mem_strobe_o in N+1.
- mem_done_i in cycle M -> requester done_o and data in M+1.
- Minimum request-to-done latency: 2 cycles plus memory latency. With mem_done_i in the strobe cycle, done_o arrives in N+2.
- Back-to-back: RESP in M+1, IDLE in M+2, next mem_strobe_o in M+3.
- done_o for both masters is never asserted in the same cycle. mem_strobe_o is never asserted outside the first WAIT cycle.

## Test plan
- I-cache read only: icache_strobe_i at cycle 10, addr 0x0000_1000. Memory returns done at cycle 14 with data 0xA5…A5 -> mem_strobe_o=1 at 11 with addr 0x1000, rw 0; icache_done_o=1 at 15 with data 0xA5…A5; dcache_done_o stays 0.
- D-cache write: dcache_strobe_i at cycle 5, rw 1, addr 0x2000, data 0x1234…. Done at 8 -> mem_rw_o=1 with data 0x1234… at 6; dcache_done_o at 9; dcache_data_o unchanged (0).
- Simultaneous strobes after reset at cycle 3 -> I-cache granted first (mem_strobe_o at 4, addr = I addr). D-cache strobe issued at RESP+2. A second simultaneous pair then grants D first.
- Strobe repeated while pending: second icache_strobe_i with addr 0x3000 is ignored -> only one mem transaction (0x1000) and one done.
- TIMEOUT=8, memory never responds -> timeout_o=1 and requester done_o=1 at strobe+11. Data unchanged. The next request proceeds normally.
- rst_i asserted during WAIT, then released -> all outputs 0 immediately. A later mem_done_i is ignored. A fresh strobe is issued with I-cache priority.
